// File: rtl/ddr4_cmd_responder.sv
// DDR4 DRAM-side command responder: decodes pins each CK_t edge, tracks init and bank state, emits RL/WL data windows.
// Latency: outputs register one edge after the command. Backpressure: pure observer, never stalls the bus.
module ddr4_cmd_responder #(
  parameter int NBANK   = 16,
  parameter int ROW_W   = 18,
  parameter int LAT_MAX = 32
) (
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             cs_n,
  input  logic             act_n,
  input  logic             RAS_n_A16,
  input  logic             CAS_n_A15,
  input  logic             WE_n_A14,
  input  logic             A17,
  input  logic             A13,
  input  logic             A12_BC_n,
  input  logic             A11,
  input  logic             A10_AP,
  input  logic [9:0]       A9_A0,
  input  logic [1:0]       bg_addr,
  input  logic [1:0]       ba_addr,
  input  logic [2:0]       CL,
  input  logic [1:0]       AL,
  input  logic [2:0]       CWL,
  input  logic [1:0]       BL,
  output logic             cmd_valid,
  output logic [3:0]       cmd_code,
  output logic [NBANK-1:0] bank_open,
  output logic [ROW_W-1:0] act_row,
  output logic             rd_win,
  output logic             wr_win,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic             cfg_err,
  output logic             init_done
);

  typedef enum logic [3:0] {
    C_DES = 4'd0, C_NOP = 4'd1, C_MRS = 4'd2, C_REF = 4'd3, C_PRE = 4'd4,
    C_PREA = 4'd5, C_ACT = 4'd6, C_WR = 4'd7, C_WRA = 4'd8, C_RD = 4'd9,
    C_RDA = 4'd10, C_ZQC = 4'd11, C_RFU = 4'd12
  } cmd_t;

  typedef enum logic [1:0] {UNINIT, CONFIG, READY} state_t;

  state_t             state;
  cmd_t               code;
  logic [3:0]         bank;
  logic [ROW_W-1:0]   row;
  logic [4:0]         clc, alc, cwlc;
  logic [5:0]         rl, wl;
  logic [2:0]         burst;
  logic [6:0]         rd_end, wr_end;
  logic               rd_fit, wr_fit, rd_issue, wr_issue, cmd_legal, err;
  logic [LAT_MAX-1:0] rd_sr, wr_sr, rd_next, wr_next;

  assign bank   = {bg_addr, ba_addr};
  assign row    = {A17, RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0};
  assign rd_win = rd_sr[0];
  assign wr_win = wr_sr[0];

  // Bit k set means the window is active k edges from now.
  function automatic logic [LAT_MAX-1:0] win_mask(input logic [5:0] lat, input logic [2:0] len);
    logic [LAT_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < LAT_MAX; i++)
      if (i >= int'(lat) && i < int'(lat) + int'(len)) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    code = C_DES;
    if (!cs_n) begin
      if (!act_n) code = C_ACT;
      else begin
        case ({RAS_n_A16, CAS_n_A15, WE_n_A14})
          3'b000:  code = C_MRS;
          3'b001:  code = C_REF;
          3'b010:  code = A10_AP ? C_PREA : C_PRE;
          3'b011:  code = C_RFU;
          3'b100:  code = A10_AP ? C_WRA : C_WR;
          3'b101:  code = A10_AP ? C_RDA : C_RD;
          3'b110:  code = C_ZQC;
          default: code = C_NOP;
        endcase
      end
    end
  end

  always_comb begin
    clc = {2'b00, CL} + 5'd9;
    case (AL)
      2'b01:   alc = clc - 5'd1;
      2'b10:   alc = clc - 5'd2;
      default: alc = 5'd0;
    endcase
    case (CWL)
      3'd0:    cwlc = 5'd9;
      3'd1:    cwlc = 5'd10;
      3'd2:    cwlc = 5'd11;
      3'd3:    cwlc = 5'd12;
      3'd4:    cwlc = 5'd14;
      3'd5:    cwlc = 5'd16;
      3'd6:    cwlc = 5'd18;
      default: cwlc = 5'd20;
    endcase
    rl     = {1'b0, alc} + {1'b0, clc};
    wl     = {1'b0, alc} + {1'b0, cwlc};
    // BL code 11 is reserved; treat it like fixed BL8.
    burst  = (BL == 2'b10 || (BL == 2'b01 && !A12_BC_n)) ? 3'd2 : 3'd4;
    rd_end = {1'b0, rl} + {4'b0000, burst};
    wr_end = {1'b0, wl} + {4'b0000, burst};
    rd_fit = int'(rd_end) < LAT_MAX;
    wr_fit = int'(wr_end) < LAT_MAX;
  end

  always_comb begin
    err       = 1'b0;
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    cmd_legal = (state == READY) || (code inside {C_DES, C_NOP, C_MRS, C_ZQC});
    if (code == C_RFU || !cmd_legal) err = 1'b1;
    else if (state == READY) begin
      case (code)
        C_ACT:        err = bank_open[bank];
        C_RD, C_RDA:  if (!bank_open[bank] || !rd_fit) err = 1'b1; else rd_issue = 1'b1;
        C_WR, C_WRA:  if (!bank_open[bank] || !wr_fit) err = 1'b1; else wr_issue = 1'b1;
        C_REF:        err = |bank_open;
        default:      err = 1'b0;
      endcase
    end
    rd_next = (rd_sr >> 1) | (rd_issue ? win_mask(rl, burst) : '0);
    wr_next = (wr_sr >> 1) | (wr_issue ? win_mask(wl, burst) : '0);
    if (rd_next[0] && wr_next[0]) err = 1'b1;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state      <= UNINIT;
      cmd_valid  <= 1'b0;
      cmd_code   <= '0;
      bank_open  <= '0;
      act_row    <= '0;
      rd_sr      <= '0;
      wr_sr      <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      cfg_err    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      cmd_valid <= !(code == C_DES || code == C_NOP);
      cmd_code  <= code;
      rd_sr     <= rd_next;
      wr_sr     <= wr_next;
      err_pulse <= err;
      cfg_err   <= (AL == 2'b11);
      if (err) err_sticky <= 1'b1;
      case (state)
        UNINIT: if (code == C_MRS) state <= CONFIG;
        CONFIG: if (code == C_ZQC) begin
          state     <= READY;
          init_done <= 1'b1;
        end
        READY: begin
          case (code)
            C_ACT: if (!bank_open[bank]) begin
              bank_open[bank] <= 1'b1;
              act_row         <= row;
            end
            C_RDA, C_WRA, C_PRE: bank_open[bank] <= 1'b0;
            C_PREA:              bank_open       <= '0;
            default: ;
          endcase
        end
        default: state <= UNINIT;
      endcase
    end
  end

endmodule
